// File: rtl/controle_noite.sv
// Night-phase sequencer: wolf, doctor and seer turns with per-turn timeout,
// then resolves whether the wolf's target died.
module controle_noite #(
    parameter int N_JOGADORES  = 8,
    parameter int TEMPO_LIMITE = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicia_noite,
    input  logic                   passa,
    input  logic [3:0]             voto,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   lobo_vivo,
    input  logic                   medico_vivo,
    input  logic                   vidente_vivo,
    output logic [1:0]             turno,
    output logic [3:0]             alvo_lobo,
    output logic [3:0]             alvo_medico,
    output logic [3:0]             alvo_vidente,
    output logic                   erro_voto,
    output logic                   morreu,
    output logic [3:0]             morto,
    output logic                   fim_noite,
    output logic [3:0]             db_estado
);

    localparam int TW = $clog2(TEMPO_LIMITE);
    localparam logic [TW-1:0] TMAX = TW'(TEMPO_LIMITE - 1);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        TURNO_LOBO    = 3'd1,
        TURNO_MEDICO  = 3'd2,
        TURNO_VIDENTE = 3'd3,
        RESOLVE       = 3'd4,
        FIM           = 3'd5
    } estado_t;

    estado_t       estado_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    alvo_lobo_q, alvo_medico_q, alvo_vidente_q, morto_q;
    logic          erro_q, morreu_q, fim_q;

    logic [15:0]   vivos_ext;
    logic          voto_valido, papel_vivo, em_turno, pula, aceita, esgotou, morte;
    estado_t       proximo_d;

    // The timer is only zero on the entry cycle, so it doubles as the entry flag for skipping.
    always_comb begin
        vivos_ext   = 16'(vivos);
        voto_valido = (32'(voto) < N_JOGADORES) && vivos_ext[voto];
        papel_vivo  = 1'b1;
        em_turno    = 1'b0;
        proximo_d   = OCIOSO;
        case (estado_q)
            TURNO_LOBO: begin
                papel_vivo = lobo_vivo;
                em_turno   = 1'b1;
                proximo_d  = TURNO_MEDICO;
            end
            TURNO_MEDICO: begin
                papel_vivo = medico_vivo;
                em_turno   = 1'b1;
                proximo_d  = TURNO_VIDENTE;
            end
            TURNO_VIDENTE: begin
                papel_vivo = vidente_vivo;
                em_turno   = 1'b1;
                proximo_d  = RESOLVE;
            end
            default: ;
        endcase
        pula    = em_turno && !papel_vivo && (timer_q == '0);
        aceita  = em_turno && !pula && passa && voto_valido;
        esgotou = timer_q == TMAX;
        morte   = (alvo_lobo_q != 4'hF) && (alvo_lobo_q != alvo_medico_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            timer_q        <= '0;
            alvo_lobo_q    <= 4'hF;
            alvo_medico_q  <= 4'hF;
            alvo_vidente_q <= 4'hF;
            morto_q        <= 4'hF;
            morreu_q       <= 1'b0;
            erro_q         <= 1'b0;
            fim_q          <= 1'b0;
        end else begin
            erro_q <= em_turno && !pula && passa && !voto_valido;
            fim_q  <= (estado_q == RESOLVE);
            case (estado_q)
                OCIOSO: begin
                    if (inicia_noite) begin
                        alvo_lobo_q    <= 4'hF;
                        alvo_medico_q  <= 4'hF;
                        alvo_vidente_q <= 4'hF;
                        morto_q        <= 4'hF;
                        morreu_q       <= 1'b0;
                        timer_q        <= '0;
                        estado_q       <= TURNO_LOBO;
                    end
                end
                TURNO_LOBO, TURNO_MEDICO, TURNO_VIDENTE: begin
                    if (pula || aceita || esgotou) begin
                        estado_q <= proximo_d;
                        timer_q  <= '0;
                        if (aceita) begin
                            case (estado_q)
                                TURNO_LOBO:    alvo_lobo_q    <= voto;
                                TURNO_MEDICO:  alvo_medico_q  <= voto;
                                default:       alvo_vidente_q <= voto;
                            endcase
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESOLVE: begin
                    morreu_q <= morte;
                    morto_q  <= morte ? alvo_lobo_q : 4'hF;
                    estado_q <= FIM;
                end
                FIM:     estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    always_comb begin
        case (estado_q)
            OCIOSO, TURNO_LOBO, TURNO_MEDICO, TURNO_VIDENTE, RESOLVE, FIM:
                db_estado = {1'b0, estado_q};
            default: db_estado = 4'hF;
        endcase
        case (estado_q)
            TURNO_LOBO:    turno = 2'd1;
            TURNO_MEDICO:  turno = 2'd2;
            TURNO_VIDENTE: turno = 2'd3;
            default:       turno = 2'd0;
        endcase
    end

    assign alvo_lobo    = alvo_lobo_q;
    assign alvo_medico  = alvo_medico_q;
    assign alvo_vidente = alvo_vidente_q;
    assign erro_voto    = erro_q;
    assign morreu       = morreu_q;
    assign morto        = morto_q;
    assign fim_noite    = fim_q;

endmodule

// File: tb/tb_controle_noite.sv
// Directed bench for controle_noite with TEMPO_LIMITE=10 so timeouts stay short.
module tb_controle_noite;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       inicia_noite = 1'b0;
    logic       passa = 1'b0;
    logic [3:0] voto = 4'd0;
    logic [7:0] vivos = 8'hFF;
    logic       lobo_vivo = 1'b1;
    logic       medico_vivo = 1'b1;
    logic       vidente_vivo = 1'b1;
    logic [1:0] turno;
    logic [3:0] alvo_lobo, alvo_medico, alvo_vidente, morto, db_estado;
    logic       erro_voto, morreu, fim_noite;

    int checks = 0;
    int errors = 0;

    controle_noite #(.N_JOGADORES(8), .TEMPO_LIMITE(10)) dut (
        .clock(clock), .reset(reset), .inicia_noite(inicia_noite), .passa(passa),
        .voto(voto), .vivos(vivos), .lobo_vivo(lobo_vivo), .medico_vivo(medico_vivo),
        .vidente_vivo(vidente_vivo), .turno(turno), .alvo_lobo(alvo_lobo),
        .alvo_medico(alvo_medico), .alvo_vidente(alvo_vidente), .erro_voto(erro_voto),
        .morreu(morreu), .morto(morto), .fim_noite(fim_noite), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge only.
    task automatic applyStimulus(input logic p, input logic [3:0] v);
        passa = p;
        voto  = v;
        @(negedge clock);
        passa = 1'b0;
    endtask

    task automatic startNight();
        inicia_noite = 1'b1;
        @(negedge clock);
        inicia_noite = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_estado", db_estado, 0);
        checkOutput("rst_turno", turno, 0);
        checkOutput("rst_alvo_lobo", alvo_lobo, 15);
        checkOutput("rst_alvo_medico", alvo_medico, 15);
        checkOutput("rst_alvo_vidente", alvo_vidente, 15);
        checkOutput("rst_morto", morto, 15);
        checkOutput("rst_morreu", morreu, 0);
        checkOutput("rst_fim", fim_noite, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle_estado", db_estado, 0);

        // Basic kill
        startNight();
        checkOutput("k_estado_lobo", db_estado, 1);
        checkOutput("k_turno_lobo", turno, 1);
        applyStimulus(1'b1, 4'd3);
        checkOutput("k_alvo_lobo", alvo_lobo, 3);
        checkOutput("k_estado_med", db_estado, 2);
        applyStimulus(1'b1, 4'd5);
        checkOutput("k_alvo_medico", alvo_medico, 5);
        checkOutput("k_turno_vid", turno, 3);
        applyStimulus(1'b1, 4'd1);
        checkOutput("k_alvo_vidente", alvo_vidente, 1);
        checkOutput("k_estado_res", db_estado, 4);
        checkOutput("k_fim_early", fim_noite, 0);
        @(negedge clock);
        checkOutput("k_estado_fim", db_estado, 5);
        checkOutput("k_fim", fim_noite, 1);
        checkOutput("k_morreu", morreu, 1);
        checkOutput("k_morto", morto, 3);
        @(negedge clock);
        checkOutput("k_fim_off", fim_noite, 0);
        checkOutput("k_estado_idle", db_estado, 0);
        checkOutput("k_hold_morto", morto, 3);
        checkOutput("k_hold_alvo", alvo_lobo, 3);

        // Doctor saves the wolf's target
        startNight();
        checkOutput("s_clr_morreu", morreu, 0);
        checkOutput("s_clr_morto", morto, 15);
        checkOutput("s_clr_alvo", alvo_lobo, 15);
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b1, 4'd0);
        @(negedge clock);
        checkOutput("s_fim", fim_noite, 1);
        checkOutput("s_morreu", morreu, 0);
        checkOutput("s_morto", morto, 15);
        @(negedge clock);

        // Invalid votes: dead player, then out of range
        vivos = 8'hF7;
        startNight();
        applyStimulus(1'b1, 4'd3);
        checkOutput("i_erro1", erro_voto, 1);
        checkOutput("i_estado1", db_estado, 1);
        applyStimulus(1'b0, 4'd0);
        checkOutput("i_erro_off", erro_voto, 0);
        applyStimulus(1'b1, 4'd9);
        checkOutput("i_erro2", erro_voto, 1);
        checkOutput("i_estado2", db_estado, 1);
        checkOutput("i_alvo_none", alvo_lobo, 15);
        applyStimulus(1'b1, 4'd4);
        checkOutput("i_alvo_lobo", alvo_lobo, 4);
        checkOutput("i_estado3", db_estado, 2);
        checkOutput("i_erro_ok", erro_voto, 0);
        applyStimulus(1'b1, 4'd7);
        checkOutput("i_alvo_med_edge", alvo_medico, 7);
        applyStimulus(1'b1, 4'd0);
        @(negedge clock);
        checkOutput("i_morto", morto, 4);
        @(negedge clock);
        vivos = 8'hFF;

        // Wolf timeout, doctor skipped
        medico_vivo = 1'b0;
        startNight();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t_lobo_cyc%0d", i), db_estado, 1);
            @(negedge clock);
        end
        checkOutput("t_estado_med", db_estado, 2);
        checkOutput("t_alvo_lobo", alvo_lobo, 15);
        @(negedge clock);
        checkOutput("t_skip_med", db_estado, 3);
        checkOutput("t_alvo_med", alvo_medico, 15);
        applyStimulus(1'b1, 4'd6);
        @(negedge clock);
        checkOutput("t_fim", fim_noite, 1);
        checkOutput("t_morreu", morreu, 0);
        @(negedge clock);
        medico_vivo = 1'b1;

        // Valid passa on the timeout cycle, then async reset in the doctor turn
        startNight();
        for (int i = 0; i < 9; i++) @(negedge clock);
        checkOutput("c_estado_pre", db_estado, 1);
        applyStimulus(1'b1, 4'd6);
        checkOutput("c_alvo_lobo", alvo_lobo, 6);
        checkOutput("c_estado_med", db_estado, 2);
        #2 reset = 1'b1;
        #1;
        checkOutput("r_estado", db_estado, 0);
        checkOutput("r_alvo_lobo", alvo_lobo, 15);
        checkOutput("r_turno", turno, 0);
        @(negedge clock);
        checkOutput("r_fim", fim_noite, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("r_fim2", fim_noite, 0);
        checkOutput("r_estado2", db_estado, 0);

        // inicia_noite ignored mid-night
        startNight();
        applyStimulus(1'b1, 4'd1);
        applyStimulus(1'b1, 4'd2);
        inicia_noite = 1'b1;
        @(negedge clock);
        inicia_noite = 1'b0;
        checkOutput("g_estado", db_estado, 3);
        checkOutput("g_alvo_lobo", alvo_lobo, 1);
        applyStimulus(1'b1, 4'd0);
        @(negedge clock);
        checkOutput("g_morreu", morreu, 1);
        checkOutput("g_morto", morto, 1);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
